// File: rtl/tm1638_pkg.sv
// ============================================================================
// Module   : tm1638_pkg
// Brief    : Shared command bytes, FSM state type and hex-to-segment decode
//            for the TM1638 display driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tm1638_pkg;

    localparam logic [7:0] CMD_DATA_WRITE = 8'h40;
    localparam logic [7:0] CMD_ADDR0      = 8'hC0;
    localparam logic [7:0] CMD_DISP_ON    = 8'h88;

    localparam int NUM_DIGITS = 8;

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_BITLO = 3'd1,
        ST_BITHI = 3'd2,
        ST_STBHI = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // bit0 = segment a ... bit6 = segment g, decimal point always off
    function automatic logic [7:0] hex2seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0:    s = 8'h3F;
            4'h1:    s = 8'h06;
            4'h2:    s = 8'h5B;
            4'h3:    s = 8'h4F;
            4'h4:    s = 8'h66;
            4'h5:    s = 8'h6D;
            4'h6:    s = 8'h7D;
            4'h7:    s = 8'h07;
            4'h8:    s = 8'h7F;
            4'h9:    s = 8'h6F;
            4'hA:    s = 8'h77;
            4'hB:    s = 8'h7C;
            4'hC:    s = 8'h39;
            4'hD:    s = 8'h5E;
            4'hE:    s = 8'h79;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tm1638_freq_div.sv
// ============================================================================
// Module   : freq_div
// Brief    : Free-running divider producing a one-cycle tick every DIV clocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module freq_div #(
    parameter int DIV = 50
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tm1638_display.sv
// ============================================================================
// Module   : tm1638_display
// Brief    : Continuous write-only TM1638 driver: 8 hex digits plus 8 LEDs,
//            streamed as 0x40 / 0xC0+16 data / 0x88|BRIGHT frames.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tm1638_display
    import tm1638_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1_000_000,
    parameter int BRIGHT  = 7
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] led,
    input  logic [3:0] seg0,
    input  logic [3:0] seg1,
    input  logic [3:0] seg2,
    input  logic [3:0] seg3,
    input  logic [3:0] seg4,
    input  logic [3:0] seg5,
    input  logic [3:0] seg6,
    input  logic [3:0] seg7,
    output logic       clk,
    output logic       stb,
    output logic       dio
);

    localparam int DIV = CLK_HZ / TICK_HZ;

    logic tick;

    freq_div #(
        .DIV (DIV)
    ) u_div (
        .CLK  (CLK),
        .RST  (RST),
        .tick (tick)
    );

    logic [NUM_DIGITS-1:0][3:0] seg_in;
    assign seg_in = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

    state_e                     state_q, state_d;
    logic [1:0]                 cmd_q,   cmd_d;
    logic [4:0]                 byte_q,  byte_d;
    logic [2:0]                 bit_q,   bit_d;
    logic                       clk_q,   clk_d;
    logic                       stb_q,   stb_d;
    logic                       dio_q,   dio_d;
    logic [7:0]                 led_q,   led_d;
    logic [NUM_DIGITS-1:0][3:0] seg_q,   seg_d;

    logic [7:0] cur_byte;
    logic [4:0] last_byte;
    logic [3:0] data_idx;

    // Byte 0 of the address command is the address; data byte k maps to
    // digit k/2, even = segments, odd = LED.
    always_comb begin
        data_idx  = 4'(byte_q - 5'd1);
        last_byte = (cmd_q == 2'd1) ? 5'd16 : 5'd0;
        case (cmd_q)
            2'd0: cur_byte = CMD_DATA_WRITE;
            2'd1: begin
                if (byte_q == 5'd0) begin
                    cur_byte = CMD_ADDR0;
                end else if (data_idx[0]) begin
                    cur_byte = {7'b0, led_q[data_idx[3:1]]};
                end else begin
                    cur_byte = hex2seg(seg_q[data_idx[3:1]]);
                end
            end
            default: cur_byte = CMD_DISP_ON | {5'b0, 3'(BRIGHT)};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        clk_d   = clk_q;
        stb_d   = stb_q;
        dio_d   = dio_q;
        led_d   = led_q;
        seg_d   = seg_q;
        if (tick) begin
            unique case (state_q)
                ST_START: begin
                    stb_d   = 1'b0;
                    byte_d  = '0;
                    bit_d   = '0;
                    state_d = ST_BITLO;
                    if (cmd_q == 2'd0) begin
                        led_d = led;
                        seg_d = seg_in;
                    end
                end
                ST_BITLO: begin
                    clk_d   = 1'b0;
                    dio_d   = cur_byte[bit_q];
                    state_d = ST_BITHI;
                end
                ST_BITHI: begin
                    clk_d   = 1'b1;
                    state_d = ST_BITLO;
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
                        if (byte_q == last_byte) begin
                            state_d = ST_STBHI;
                        end else begin
                            byte_d = byte_q + 5'd1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
                ST_STBHI: begin
                    stb_d   = 1'b1;
                    state_d = ST_GAP;
                end
                ST_GAP: begin
                    state_d = ST_START;
                    cmd_d   = (cmd_q == 2'd2) ? 2'd0 : cmd_q + 2'd1;
                end
                default: state_d = ST_START;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_START;
            cmd_q   <= '0;
            byte_q  <= '0;
            bit_q   <= '0;
            clk_q   <= 1'b1;
            stb_q   <= 1'b1;
            dio_q   <= 1'b1;
            led_q   <= '0;
            seg_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            clk_q   <= clk_d;
            stb_q   <= stb_d;
            dio_q   <= dio_d;
            led_q   <= led_d;
            seg_q   <= seg_d;
        end
    end

    assign clk = clk_q;
    assign stb = stb_q;
    assign dio = dio_q;

endmodule

`default_nettype wire

// File: tb/tb_tm1638_display.sv
// ============================================================================
// Module   : tb_tm1638_display
// Brief    : Scoreboard bench: decodes the serial stream of a DIV=2 instance
//            byte by byte and checks tick spacing on a DIV=50 instance.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tm1638_display;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] led;
    logic [3:0] seg [8];
    logic       clk_a, stb_a, dio_a;
    logic       clk_b, stb_b, dio_b;

    always #5 CLK = ~CLK;

    tm1638_display #(
        .CLK_HZ  (2_000_000),
        .TICK_HZ (1_000_000),
        .BRIGHT  (7)
    ) u_dut_a (
        .CLK (CLK), .RST (RST), .led (led),
        .seg0 (seg[0]), .seg1 (seg[1]), .seg2 (seg[2]), .seg3 (seg[3]),
        .seg4 (seg[4]), .seg5 (seg[5]), .seg6 (seg[6]), .seg7 (seg[7]),
        .clk (clk_a), .stb (stb_a), .dio (dio_a)
    );

    tm1638_display u_dut_b (
        .CLK (CLK), .RST (RST), .led (led),
        .seg0 (seg[0]), .seg1 (seg[1]), .seg2 (seg[2]), .seg3 (seg[3]),
        .seg4 (seg[4]), .seg5 (seg[5]), .seg6 (seg[6]), .seg7 (seg[7]),
        .clk (clk_b), .stb (stb_b), .dio (dio_b)
    );

    localparam logic [7:0] SEG_TBL [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    typedef struct {
        int         frame;
        int         pos;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   bidx   = 0;
    int   n_b    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_frame(input int fr);
        exp_t e;
        e.frame = fr;
        e.pos = 0;  e.val = 8'h40; sb.push_back(e);
        e.pos = 1;  e.val = 8'hC0; sb.push_back(e);
        for (int i = 0; i < 8; i++) begin
            e.pos = 2 + 2 * i; e.val = SEG_TBL[seg[i]];   sb.push_back(e);
            e.pos = 3 + 2 * i; e.val = {7'b0, led[i]};    sb.push_back(e);
        end
        e.pos = 18; e.val = 8'h8F; sb.push_back(e);
    endfunction

    task automatic wait_bytes(input int target, input int budget);
        int n = 0;
        while (bidx < target && n < budget) begin
            @(posedge CLK);
            n++;
        end
        check("wait_bytes", 32'(bidx >= target), 32'd1);
    endtask

    // Serial decoder for the DIV=2 instance
    initial begin
        logic       pc, ps, have_rise, have_fs;
        logic [7:0] sh;
        int         bc, rise_cyc, fs_cyc, fr, pos;
        pc = 1'b1; ps = 1'b1; have_rise = 1'b0; have_fs = 1'b0;
        sh = '0; bc = 0; rise_cyc = 0; fs_cyc = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (!RST) begin
                pc = 1'b1; ps = 1'b1; bc = 0; bidx = 0;
                have_rise = 1'b0; have_fs = 1'b0;
            end else begin
                if (!pc && clk_a && !stb_a) begin
                    sh = {dio_a, sh[7:1]};
                    bc++;
                    if (bc == 8) begin
                        bc  = 0;
                        fr  = bidx / 19;
                        pos = bidx % 19;
                        if (sb.size() > 0) begin
                            if (sb[0].frame == fr && sb[0].pos == pos) begin
                                check($sformatf("byte_f%0d_p%0d", fr, pos), 32'(sh), 32'(sb[0].val));
                                void'(sb.pop_front());
                            end else if (sb[0].frame * 19 + sb[0].pos < bidx) begin
                                check("sb_missed", 32'(bidx), 32'(sb[0].frame * 19 + sb[0].pos));
                                void'(sb.pop_front());
                            end
                        end
                        bidx++;
                    end
                end
                if (!ps && stb_a) begin
                    check("cmd_bit_align", 32'(bc), 32'd0);
                    rise_cyc  = cyc;
                    have_rise = 1'b1;
                end
                if (ps && !stb_a) begin
                    if (have_rise) check("stb_gap", 32'(cyc - rise_cyc), 32'd4);
                    if (bidx % 19 == 0) begin
                        if (have_fs) check("frame_period", 32'(cyc - fs_cyc), 32'd626);
                        fs_cyc  = cyc;
                        have_fs = 1'b1;
                    end
                end
                pc = clk_a;
                ps = stb_a;
            end
        end
    end

    // Tick spacing on the DIV=50 instance, first command only
    initial begin
        logic pcb, psb, fall_seen;
        int   cb, last_edge;
        pcb = 1'b1; psb = 1'b1; fall_seen = 1'b0; cb = 0; last_edge = -1;
        forever begin
            @(posedge CLK);
            #1;
            if (!RST) begin
                cb = 0; pcb = 1'b1; psb = 1'b1; last_edge = -1;
            end else begin
                cb++;
                if (psb && !stb_b && !fall_seen) begin
                    check("divB_first_tick", 32'(cb), 32'd50);
                    fall_seen = 1'b1;
                end
                if (pcb != clk_b && n_b < 15) begin
                    if (last_edge >= 0) begin
                        check("divB_edge_spacing", 32'(cb - last_edge), 32'd50);
                        n_b++;
                    end
                    last_edge = cb;
                end
                pcb = clk_b;
                psb = stb_b;
            end
        end
    end

    initial begin
        int n;
        led    = 8'hAA;
        seg[0] = 4'h0; seg[1] = 4'h9; seg[2] = 4'h5; seg[3] = 4'h1;
        seg[4] = 4'hD; seg[5] = 4'hF; seg[6] = 4'hC; seg[7] = 4'hE;
        RST    = 1'b0;

        repeat (4) @(posedge CLK);
        #1;
        check("rst_clk_a", 32'(clk_a), 32'd1);
        check("rst_stb_a", 32'(stb_a), 32'd1);
        check("rst_dio_a", 32'(dio_a), 32'd1);
        check("rst_clk_b", 32'(clk_b), 32'd1);
        check("rst_stb_b", 32'(stb_b), 32'd1);
        check("rst_dio_b", 32'(dio_b), 32'd1);

        push_frame(0);
        push_frame(1);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        check("stb_before_tick", 32'(stb_a), 32'd1);
        @(posedge CLK); #1;
        check("stb_first_tick", 32'(stb_a), 32'd0);

        // Mid data command of frame 1: the new seg3 must wait for frame 2
        wait_bytes(19 + 4, 2000);
        seg[3] = 4'h2;
        push_frame(2);
        wait_bytes(57, 3000);
        check("sb_drained", 32'(sb.size()), 32'd0);

        n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (clk_a !== 1'b0 && n < 50);
        check("found_bitlo", 32'(clk_a), 32'd0);
        #3;
        RST = 1'b0;
        #1;
        check("async_rst_clk", 32'(clk_a), 32'd1);
        check("async_rst_stb", 32'(stb_a), 32'd1);
        check("async_rst_dio", 32'(dio_a), 32'd1);
        push_frame(0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        wait_bytes(19, 1500);
        check("sb_drained_after_rst", 32'(sb.size()), 32'd0);
        check("divB_edges_seen", 32'(n_b), 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
